// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: round-robin arbitration, one operation in flight,
// registered result held until the consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    logic [1:0]       r_state;
    logic             r_lastGrant;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic             r_err;

    logic             w_idle;
    logic             w_grant1;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_resData;
    logic             w_resCarry;
    logic             w_resErr;

    // Requester 1 wins when it is alone, or when both contend and 0 went last.
    assign w_idle     = (r_state == S_IDLE);
    assign w_grant1   = req1_valid && (!req0_valid || (r_lastGrant == 1'b0));
    assign w_accept   = w_idle && (req0_valid || req1_valid);
    assign req0_ready = rst_n && w_idle && req0_valid && !w_grant1;
    assign req1_ready = rst_n && w_idle && w_grant1;

    assign rsp_valid  = (r_state == S_RESP);
    assign busy       = !w_idle;
    assign rsp_id     = r_id;
    assign rsp_data   = r_data;
    assign rsp_carry  = r_carry;
    assign rsp_err    = r_err;

    // The extra top bit of the subtraction is the borrow (a < b unsigned).
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_resData  = '0;
        w_resCarry = 1'b0;
        w_resErr   = 1'b0;
        case (r_op)
            OP_NOT: w_resData = ~r_a;
            OP_AND: w_resData = r_a & r_b;
            OP_OR:  w_resData = r_a | r_b;
            OP_XOR: w_resData = r_a ^ r_b;
            OP_ADD: begin
                w_resData  = w_sum[WIDTH-1:0];
                w_resCarry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_resData  = w_diff[WIDTH-1:0];
                w_resCarry = w_diff[WIDTH];
            end
            default: w_resErr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lastGrant <= 1'b1;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            r_data      <= '0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op        <= w_grant1 ? req1_op : req0_op;
                        r_a         <= w_grant1 ? req1_a  : req0_a;
                        r_b         <= w_grant1 ? req1_b  : req0_b;
                        r_id        <= w_grant1;
                        r_lastGrant <= w_grant1;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_data  <= w_resData;
                    r_carry <= w_resCarry;
                    r_err   <= w_resErr;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses, a monitor
// pops and compares them on each response handshake.
module tb_alu_arbiter;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             err;
    } rsp_t;

    typedef struct packed {
        logic             id;
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
    logic [WIDTH-1:0] rsp_data;

    rsp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected response", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                checkOutput("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                checkOutput("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.carry});
                checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic pushExp(input logic id, input logic [WIDTH-1:0] data, input logic carry, input logic err);
        rsp_t e;
        e.id = id; e.data = data; e.carry = carry; e.err = err;
        expQ.push_back(e);
    endtask

    task automatic setReq(input logic id, input logic valid, input logic [2:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (id) begin
            req1_valid = valid; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = valid; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Raise one request, wait for its handshake, then drop valid just after the edge.
    task automatic applyStimulus(input logic id, input logic [2:0] op,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit got = 0;
        setReq(id, 1'b1, op, a, b);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) got = 1;
            else @(posedge clk);
        end
        if (!got) checkOutput("grant timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        setReq(id, 1'b0, 3'b000, 16'h0000, 16'h0000);
    endtask

    task automatic waitIdle();
        bit idle = 0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1;
        end
        if (!idle) checkOutput("idle timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    vec_t table_v[7];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        setReq(1'b0, 1'b1, 3'b100, 16'h1111, 16'h2222);
        setReq(1'b1, 1'b1, 3'b100, 16'h3333, 16'h4444);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset req0_ready", {31'd0, req0_ready}, 32'd0);
        checkOutput("reset req1_ready", {31'd0, req1_ready}, 32'd0);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_id", {31'd0, rsp_id}, 32'd0);
        checkOutput("reset rsp_data", {16'd0, rsp_data}, 32'd0);
        checkOutput("reset rsp_carry", {31'd0, rsp_carry}, 32'd0);
        checkOutput("reset rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        setReq(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        setReq(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD with carry-out, checking the two-cycle response latency.
        pushExp(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b100, 16'hFFFF, 16'h0001);
        @(negedge clk);
        checkOutput("exec rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("exec busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("latency rsp_valid N+2", {31'd0, rsp_valid}, 32'd1);
        waitIdle();

        // Continuous contention after reset alternates 0,1,0,1 starting with 0.
        doReset();
        pushExp(1'b0, 16'hF000, 1'b0, 1'b0);
        pushExp(1'b1, 16'hFFFE, 1'b1, 1'b0);
        pushExp(1'b0, 16'hF000, 1'b0, 1'b0);
        pushExp(1'b1, 16'hFFFE, 1'b1, 1'b0);
        setReq(1'b0, 1'b1, 3'b001, 16'hF0F0, 16'hFF00);
        setReq(1'b1, 1'b1, 3'b101, 16'h0003, 16'h0005);
        begin
            int grants = 0;
            for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    if (grants == 0) checkOutput("first grant cycle", cyc, 0);
                    checkOutput("rr both ready", {31'd0, req0_ready && req1_ready}, 32'd0);
                    checkOutput("rr grant id", {31'd0, req1_ready}, grants % 2);
                    grants++;
                end
                @(posedge clk); #1;
            end
            if (grants < 4) checkOutput("rr grant count", grants, 4);
        end
        setReq(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        setReq(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        waitIdle();

        // Back-pressure: response must hold steady while the consumer stalls.
        rsp_ready = 1'b0;
        pushExp(1'b1, 16'hEDCB, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'b000, 16'h1234, 16'h0000);
        req0_valid = 1'b1; req0_op = 3'b100; req0_a = 16'h0001; req0_b = 16'h0001;
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) seen = 1;
                else @(posedge clk);
            end
            if (!seen) checkOutput("rsp_valid timeout", 32'd0, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold rsp_data", {16'd0, rsp_data}, 32'h0000EDCB);
            checkOutput("hold rsp_id", {31'd0, rsp_id}, 32'd1);
            checkOutput("hold readys", {30'd0, req0_ready, req1_ready}, 32'd0);
            checkOutput("hold busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        waitIdle();

        // Illegal opcode still completes with the error flag.
        pushExp(1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'b110, 16'h5555, 16'h0000);
        waitIdle();
        checkOutput("illegal back to idle", {31'd0, busy}, 32'd0);

        table_v[0] = '{1'b0, 3'b010, 16'h0F0F, 16'h00FF, 16'h0FFF, 1'b0, 1'b0};
        table_v[1] = '{1'b1, 3'b011, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0};
        table_v[2] = '{1'b0, 3'b100, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
        table_v[3] = '{1'b1, 3'b101, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
        table_v[4] = '{1'b1, 3'b101, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0};
        table_v[5] = '{1'b1, 3'b111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
        table_v[6] = '{1'b0, 3'b000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            pushExp(table_v[i].id, table_v[i].data, table_v[i].carry, table_v[i].err);
            applyStimulus(table_v[i].id, table_v[i].op, table_v[i].a, table_v[i].b);
            waitIdle();
        end

        // Reset mid-EXEC aborts the XOR silently and re-arms requester 0 priority.
        applyStimulus(1'b0, 3'b011, 16'hFFFF, 16'h0F0F);
        #2;
        rst_n = 1'b0;
        setReq(1'b0, 1'b1, 3'b100, 16'h0001, 16'h0002);
        setReq(1'b1, 1'b1, 3'b001, 16'hFFFF, 16'h00FF);
        #1;
        checkOutput("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort rsp_data", {16'd0, rsp_data}, 32'd0);
        checkOutput("abort readys", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pushExp(1'b0, 16'h0003, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post-reset req0_ready", {31'd0, req0_ready}, 32'd1);
        checkOutput("post-reset req1_ready", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        setReq(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
        setReq(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
        waitIdle();
        repeat (3) @(posedge clk);

        checkOutput("scoreboard drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
